// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with a programmable terminal value,
// wrap/saturate limit mode, parallel load and a built-in prescaler.
// Count range is 0..modulus_i. tick_o/event_o are registered and describe
// the step taken at the preceding edge; tc_o is combinational.
module mod_counter #(
  parameter int N  = 6,
  parameter int PW = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,      // async, active-low
  input  logic          clear_i,
  input  logic          enable_i,
  input  logic          up_i,
  input  logic          load_i,
  input  logic [N-1:0]  load_value_i,
  input  logic [N-1:0]  modulus_i,
  input  logic          saturate_i,
  input  logic [PW-1:0] prescale_i,
  output logic [N-1:0]  count_o,
  output logic          tc_o,
  output logic          tick_o,
  output logic          event_o
);

  logic [N-1:0]  count_q, count_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          event_q, event_d;
  logic          step;

  // Prescaler: decides whether this enabled cycle applies a step. Using >=
  // lets a lowered prescale take effect on the very next enabled cycle.
  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (clear_i || load_i) begin
      pre_d = '0;
    end else if (enable_i) begin
      if (pre_q >= prescale_i) begin
        step  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Count next-state: clear > load > step; tick/event flag the applied step.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    event_d = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      // Out-of-range loads are clamped to the terminal value.
      count_d = (load_value_i > modulus_i) ? modulus_i : load_value_i;
    end else if (step) begin
      tick_d = 1'b1;
      if (up_i) begin
        if (count_q < modulus_i) begin
          count_d = count_q + N'(1);
        end else begin
          // At or above the limit (modulus may have been lowered).
          event_d = 1'b1;
          count_d = saturate_i ? modulus_i : '0;
        end
      end else begin
        if (count_q > modulus_i) begin
          // Modulus lowered under a running count: snap back into range
          // quietly, this is not a limit hit.
          count_d = modulus_i;
        end else if (count_q == '0) begin
          event_d = 1'b1;
          count_d = saturate_i ? '0 : modulus_i;
        end else begin
          count_d = count_q - N'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      event_q <= event_d;
    end
  end

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign event_o = event_q;
  // Terminal flag tracks the limit of the current direction.
  assign tc_o    = up_i ? (count_q == modulus_i) : (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: integer reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_mod_counter;
  localparam int N  = 6;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          enable = 1'b0;
  logic          up = 1'b1;
  logic          load = 1'b0;
  logic [N-1:0]  load_value = '0;
  logic [N-1:0]  modulus = '0;
  logic          saturate = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [N-1:0]  count;
  logic          tc, tick, evt;

  int checks = 0;
  int errors = 0;

  mod_counter #(.N(N), .PW(PW)) dut (
    .clock_i(clock), .reset_i(reset), .clear_i(clear), .enable_i(enable),
    .up_i(up), .load_i(load), .load_value_i(load_value), .modulus_i(modulus),
    .saturate_i(saturate), .prescale_i(prescale), .count_o(count),
    .tc_o(tc), .tick_o(tick), .event_o(evt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic from the counter's rules.
  int m_count = 0, m_pre = 0, m_tick = 0, m_event = 0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_count = 0; m_pre = 0; m_tick = 0; m_event = 0;
    end else begin
      int lim;
      lim = int'(modulus);
      m_tick = 0; m_event = 0;
      if (clear) begin
        m_count = 0; m_pre = 0;
      end else if (load) begin
        m_count = (int'(load_value) < lim) ? int'(load_value) : lim;
        m_pre = 0;
      end else if (enable) begin
        if (m_pre < int'(prescale)) m_pre = m_pre + 1;
        else begin
          m_pre = 0;
          m_tick = 1;
          if (up) begin
            if (m_count + 1 <= lim) m_count = m_count + 1;
            else begin m_event = 1; m_count = saturate ? lim : 0; end
          end else begin
            if (m_count > lim) m_count = lim;
            else if (m_count == 0) begin m_event = 1; m_count = saturate ? 0 : lim; end
            else m_count = m_count - 1;
          end
        end
      end
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clock) begin
    chk("cyc_count", int'(count), m_count);
    chk("cyc_tick", int'(tick), m_tick);
    chk("cyc_event", int'(evt), m_event);
    chk("cyc_tc", int'(tc), up ? int'(m_count == int'(modulus)) : int'(m_count == 0));
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #1 reset = 1'b0;          // async assert
    #2;
    chk("rst_count", int'(count), 0);
    step(2);
    reset = 1'b1;             // release away from the edge

    // Wrap up: modulus 5, prescale 0
    clear = 1'b1; step(1); clear = 1'b0;
    modulus = 6'd5; prescale = '0; up = 1'b1; saturate = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("wrap_count", int'(count), i % 6);
      chk("wrap_tick", int'(tick), 1);
      chk("wrap_event", int'(evt), (i == 6) ? 1 : 0);
      chk("wrap_tc", int'(tc), (i == 5) ? 1 : 0);
    end

    // Load clamp then saturating count down
    enable = 1'b0; modulus = 6'd7; load_value = 6'd9; load = 1'b1;
    step(1); load = 1'b0;
    chk("clamp_count", int'(count), 7);
    chk("clamp_tick", int'(tick), 0);
    up = 1'b0; saturate = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      chk("satdn_count", int'(count), (i <= 7) ? 7 - i : 0);
      chk("satdn_event", int'(evt), (i >= 8) ? 1 : 0);
    end

    // Prescaler: step every 4th edge; a 2-cycle enable drop delays by 2
    enable = 1'b0; clear = 1'b1; step(1); clear = 1'b0;
    prescale = 4'd3; modulus = 6'd63; up = 1'b1; saturate = 1'b0; enable = 1'b1;
    step(3); chk("pre_e3", int'(count), 0);
    step(1); chk("pre_e4", int'(count), 1);
    step(4); chk("pre_e8", int'(count), 2);
    step(2); enable = 1'b0;
    step(2); enable = 1'b1;
    step(1); chk("pre_e13", int'(count), 2);
    step(1); chk("pre_e14", int'(count), 3);
    chk("pre_e14_tick", int'(tick), 1);

    // Reset mid-count at 23, down direction
    prescale = '0; load_value = 6'd22; load = 1'b1; step(1); load = 1'b0;
    step(1); chk("mid_count", int'(count), 23);
    enable = 1'b0; up = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_tick", int'(tick), 0);
    chk("rst_mid_event", int'(evt), 0);
    chk("rst_mid_tc", int'(tc), 1);
    step(1); reset = 1'b1;

    // Priority
    load_value = 6'd30; load = 1'b1; step(1);
    chk("pri_pre", int'(count), 30);
    clear = 1'b1; enable = 1'b1; load_value = 6'd12; step(1);
    chk("pri_clear", int'(count), 0);
    clear = 1'b0; step(1);
    chk("pri_load", int'(count), 12);
    chk("pri_load_tick", int'(tick), 0);
    load = 1'b0; enable = 1'b0;

    // Modulus lowered under a running count
    modulus = 6'd50; load_value = 6'd40; load = 1'b1; step(1); load = 1'b0;
    modulus = 6'd10; up = 1'b1; saturate = 1'b0; enable = 1'b1; step(1); enable = 1'b0;
    chk("modlow_up_count", int'(count), 0);
    chk("modlow_up_event", int'(evt), 1);
    modulus = 6'd50; load = 1'b1; step(1); load = 1'b0;
    modulus = 6'd10; up = 1'b0; enable = 1'b1; step(1); enable = 1'b0;
    chk("modlow_dn_count", int'(count), 10);
    chk("modlow_dn_event", int'(evt), 0);
    chk("modlow_dn_tick", int'(tick), 1);

    // modulus 0: constant 0, every step raises event
    modulus = '0; up = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("mod0_count", int'(count), 0);
      chk("mod0_event", int'(evt), 1);
    end
    enable = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
